// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle o_tick every DIV clocks; i_restart
// realigns the phase so the first tick lands DIV clocks later.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == CW'(DIV - 1));
    cnt_d  = o_tick ? '0 : cnt_q + CW'(1);
    if (i_restart) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampling, majority vote, parity/framing/break
// detection. Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FWFT output FIFO.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_perr,
  output logic                 o_ferr,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overrun,
  output logic                 o_break
);

  localparam int unsigned DIV = CLOCK_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned WW  = DATA_BITS + 2;

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_core: CLOCK_HZ too low for BAUD_RATE*16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_EVEN || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
    $error("uart_rx_core: illegal PARITY or STOP_BITS");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_core: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic                 rx_s1_q, rx_s2_q;
  logic [1:0]           settle_q;
  logic                 armed_q, armed_d;
  uart_state_e          state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 par_q, par_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, restart, maj, push, pop;
  logic                 frame_perr, frame_ferr, frame_brk;
  logic [WW-1:0]        push_word, head_word;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (restart),
    .o_tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_d      = par_q;
    brk_d      = 1'b0;
    restart    = 1'b0;
    push       = 1'b0;
    frame_ferr = 1'b0;
    maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
    frame_perr = (PARITY != PARITY_NONE) && ((^shift_q ^ par_q) != (PARITY == PARITY_ODD));
    frame_brk  = (shift_q == '0) && ((PARITY == PARITY_NONE) || !par_q);
    // The synchroniser holds its reset value for two clocks; only a line seen
    // high after that arms start detection, so a low line left over from an
    // interrupted frame is not mistaken for a new start bit.
    armed_d    = armed_q | (settle_q[1] & rx_s2_q);

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_s2_q) begin
          state_d  = ST_START;
          restart  = 1'b1;
          os_cnt_d = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s2_q) state_d = ST_IDLE;
      end
      default: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd7) samp_d[0] = rx_s2_q;
          if (os_cnt_q == 4'd8) samp_d[1] = rx_s2_q;
          if (os_cnt_q == 4'd9) begin
            case (state_q)
              ST_START:  if (maj) state_d = ST_IDLE;
              ST_DATA:   shift_d = {maj, shift_q[DATA_BITS-1:1]};
              ST_PARITY: par_d = maj;
              ST_STOP: begin
                if (!maj) begin
                  push       = 1'b1;
                  frame_ferr = 1'b1;
                  brk_d      = frame_brk;
                  state_d    = ST_WAIT_HIGH;
                end else if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                  push    = 1'b1;
                  state_d = ST_IDLE;
                end
              end
              default: ;
            endcase
          end
          if (os_cnt_q == 4'd15) begin
            case (state_q)
              ST_START: begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
              end
              ST_DATA: begin
                if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  bit_cnt_d = '0;
                end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                end
              end
              ST_PARITY: begin
                state_d   = ST_STOP;
                bit_cnt_d = '0;
              end
              ST_STOP: bit_cnt_d = bit_cnt_q + 4'd1;
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      settle_q  <= '0;
      armed_q   <= 1'b0;
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
      par_q     <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_s1_q   <= i_uart_rx;
      rx_s2_q   <= rx_s1_q;
      settle_q  <= {settle_q[0], 1'b1};
      armed_q   <= armed_d;
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      par_q     <= par_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
    end
  end

  assign push_word = {shift_q, frame_perr, frame_ferr};
  assign pop       = o_valid & i_ready;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          full, empty, do_push;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && (!full || pop);
    ovr_d   = push && full && !pop;
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(pop);
    o_valid = !empty;
    head_word = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_word;
  end
`else
  logic [WW-1:0] hold_q, hold_d;
  logic          valid_q, valid_d;

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = push && valid_q && !pop;
    if (pop) valid_d = 1'b0;
    if (push && (!valid_q || pop)) begin
      valid_d = 1'b1;
      hold_d  = push_word;
    end
    o_valid   = valid_q;
    head_word = hold_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end
`endif

  assign {o_data, o_perr, o_ferr} = head_word;
  assign o_overrun = ovr_q;
  assign o_break   = brk_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench: an 8N1 and a 7E1 receiver at 32 MHz / 1 Mbaud (32 clk/bit).
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 32000000;
  localparam int unsigned BAUD   = 1000000;
  localparam int          BCLK   = 32;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       rx8, rdy8, pe8, fe8, v8, ovr8, brk8;
  logic [7:0] d8;
  logic       rx7, rdy7, pe7, fe7, v7, ovr7, brk7;
  logic [6:0] d7;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned brk_cnt8 = 0, ovr_cnt8 = 0;
  logic [9:0]  q8[$];
  int unsigned t8[$];
  logic [8:0]  q7[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  uart_rx_core #(
    .CLOCK_HZ (CLK_HZ), .BAUD_RATE (BAUD), .DATA_BITS (8),
    .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) u_dut8 (
    .i_clk (i_clk), .i_rst (i_rst), .i_uart_rx (rx8), .o_data (d8),
    .o_perr (pe8), .o_ferr (fe8), .o_valid (v8), .i_ready (rdy8),
    .o_overrun (ovr8), .o_break (brk8)
  );

  uart_rx_core #(
    .CLOCK_HZ (CLK_HZ), .BAUD_RATE (BAUD), .DATA_BITS (7),
    .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) u_dut7 (
    .i_clk (i_clk), .i_rst (i_rst), .i_uart_rx (rx7), .o_data (d7),
    .o_perr (pe7), .o_ferr (fe7), .o_valid (v7), .i_ready (rdy7),
    .o_overrun (ovr7), .o_break (brk7)
  );

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (v8 && rdy8) begin
        q8.push_back({d8, pe8, fe8});
        t8.push_back(cyc);
      end
      if (v7 && rdy7) q7.push_back({d7, pe7, fe7});
      if (brk8) brk_cnt8++;
      if (ovr8) ovr_cnt8++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one 10-bit frame starting at a negedge; glitch flips the line for
  // one clock at that offset, rst_at pulses i_rst for 4 clocks at that offset.
  task automatic send_frame(input bit to7, input logic [7:0] data, input bit bad_par,
                            input int glitch, input int rst_at, output int unsigned start_cyc);
    logic [9:0] fr;
    logic       lv;
    if (to7) fr = {1'b1, (^data[6:0]) ^ bad_par, data[6:0], 1'b0};
    else     fr = {1'b1, data, 1'b0};
    @(negedge i_clk);
    start_cyc = cyc;
    for (int c = 0; c < 10 * BCLK; c++) begin
      lv = fr[c / BCLK] ^ (c == glitch);
      if (to7) rx7 = lv;
      else     rx8 = lv;
      if (rst_at >= 0 && c == rst_at)     i_rst = 1'b1;
      if (rst_at >= 0 && c == rst_at + 4) i_rst = 1'b0;
      @(negedge i_clk);
    end
    rx7 = 1'b1;
    rx8 = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BCLK) @(negedge i_clk);
  endtask

  function automatic logic [9:0] pop8();
    if (q8.size() == 0) return '1;
    void'(t8.pop_front());
    return q8.pop_front();
  endfunction

  function automatic logic [8:0] pop7();
    if (q7.size() == 0) return '1;
    return q7.pop_front();
  endfunction

  int unsigned s;

  initial begin
    rx8 = 1'b1; rx7 = 1'b1; rdy8 = 1'b1; rdy7 = 1'b1; i_rst = 1'b1;
    repeat (4) @(negedge i_clk);
    check_eq("rst_valid", 32'(v8), 32'd0);
    check_eq("rst_data", 32'(d8), 32'd0);
    check_eq("rst_perr", 32'(pe8), 32'd0);
    check_eq("rst_ferr", 32'(fe8), 32'd0);
    check_eq("rst_ovr", 32'(ovr8), 32'd0);
    check_eq("rst_brk", 32'(brk8), 32'd0);
    i_rst = 1'b0;
    idle_bits(2);

    // 8N1 0xA5: word visible 311 clocks after the start edge is driven
    send_frame(1'b0, 8'hA5, 1'b0, -1, -1, s);
    idle_bits(2);
    check_eq("a5_count", 32'(q8.size()), 32'd1);
    if (t8.size() > 0) check_eq("a5_latency", t8[0] - s, 32'd311);
    else               check_eq("a5_latency", 32'hFFFF_FFFF, 32'd311);
    check_eq("a5_word", 32'(pop8()), {22'd0, 8'hA5, 2'b00});

    // 7E1 0x41 with bad then good parity
    send_frame(1'b1, 8'h41, 1'b1, -1, -1, s);
    idle_bits(2);
    check_eq("par_bad_count", 32'(q7.size()), 32'd1);
    check_eq("par_bad_word", 32'(pop7()), {23'd0, 7'h41, 2'b10});
    send_frame(1'b1, 8'h41, 1'b0, -1, -1, s);
    idle_bits(2);
    check_eq("par_ok_word", 32'(pop7()), {23'd0, 7'h41, 2'b00});

    // quarter-bit glitch on idle line is a false start
    @(negedge i_clk);
    rx8 = 1'b0;
    repeat (8) @(negedge i_clk);
    rx8 = 1'b1;
    idle_bits(2);
    check_eq("glitch_idle_count", 32'(q8.size()), 32'd0);
    check_eq("glitch_idle_state", 32'(u_dut8.state_q), 32'(ST_IDLE));

    // one-clock dip at mid-bit of data bit 3 is outvoted
    send_frame(1'b0, 8'hFF, 1'b0, 4 * BCLK + 16, -1, s);
    idle_bits(2);
    check_eq("glitch_bit_word", 32'(pop8()), {22'd0, 8'hFF, 2'b00});

    // break: line low for three frame times
    @(negedge i_clk);
    rx8 = 1'b0;
    repeat (30 * BCLK) @(negedge i_clk);
    check_eq("brk_count_low", 32'(q8.size()), 32'd1);
    rx8 = 1'b1;
    idle_bits(3);
    check_eq("brk_pulses", brk_cnt8, 32'd1);
    check_eq("brk_count", 32'(q8.size()), 32'd1);
    check_eq("brk_word", 32'(pop8()), {22'd0, 8'h00, 2'b01});

    // overrun with consumer stalled
    @(posedge i_clk); #1 rdy8 = 1'b0;
`ifdef UART_RX_FIFO_EN
    for (int v = 1; v <= 5; v++) begin
      send_frame(1'b0, 8'(v), 1'b0, -1, -1, s);
      idle_bits(1);
    end
    check_eq("ovr_pulses", ovr_cnt8, 32'd1);
    check_eq("ovr_head", 32'(d8), 32'h01);
    @(posedge i_clk); #1 rdy8 = 1'b1;
    idle_bits(1);
    check_eq("ovr_fifo_count", 32'(q8.size()), 32'd4);
    for (int v = 1; v <= 4; v++)
      check_eq("ovr_fifo_word", 32'(pop8()), {22'd0, 8'(v), 2'b00});
`else
    send_frame(1'b0, 8'h01, 1'b0, -1, -1, s);
    idle_bits(1);
    send_frame(1'b0, 8'h02, 1'b0, -1, -1, s);
    idle_bits(1);
    check_eq("ovr_pulses", ovr_cnt8, 32'd1);
    check_eq("ovr_hold_data", 32'(d8), 32'h01);
    check_eq("ovr_hold_valid", 32'(v8), 32'd1);
    @(posedge i_clk); #1 rdy8 = 1'b1;
    idle_bits(1);
    check_eq("ovr_hold_count", 32'(q8.size()), 32'd1);
    check_eq("ovr_hold_word", 32'(pop8()), {22'd0, 8'h01, 2'b00});
`endif

    // reset during data bit 4 discards the frame; the next one is clean
    send_frame(1'b0, 8'h0F, 1'b0, -1, 5 * BCLK + 10, s);
    idle_bits(2);
    check_eq("rst_mid_count", 32'(q8.size()), 32'd0);
    send_frame(1'b0, 8'h3C, 1'b0, -1, -1, s);
    idle_bits(2);
    check_eq("post_rst_count", 32'(q8.size()), 32'd1);
    check_eq("post_rst_word", 32'(pop8()), {22'd0, 8'h3C, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, RX FIFO entries; power of 2, at least 2; used only with UART_RX_FIFO_EN.
REQ-007 SHALL have port i_clk, input, width 1, clock.
REQ-008 SHALL have port i_rst, input, width 1, reset; synchronous, active-high.
REQ-009 SHALL have port i_uart_rx, input, width 1, asynchronous serial line; idle level is high.
REQ-010 SHALL have port o_data, output, width DATA_BITS, received word, LSB = first bit on the line.
REQ-011 SHALL have port o_perr, output, width 1, parity error for the word on o_data.
REQ-012 SHALL have port o_ferr, output, width 1, framing error for the word on o_data.
REQ-013 SHALL have port o_valid, output, width 1, word available.
REQ-014 SHALL have port i_ready, input, width 1, consumer accepts the word.
REQ-015 SHALL have port o_overrun, output, width 1, one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port o_break, output, width 1, one-cycle pulse on break detection.

Function
REQ-017 SHALL pass i_uart_rx through a 2-flop synchroniser; both flops reset to 1.
REQ-018 SHALL generate a 16x oversample tick every DIV = CLOCK_HZ/(BAUD_RATE*16) clocks, with DIV >= 1 enforced by elaboration check.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 SHALL leave IDLE for START when the synchronised line is low, restarting the tick phase at that point.
REQ-021 SHALL take each bit value as the 2-of-3 majority of the samples at ticks 7, 8 and 9 of that bit.
REQ-022 SHALL return from START to IDLE when the start-bit majority is 1 (false start), with no output.
REQ-023 SHALL shift DATA_BITS bits LSB first, then enter PARITY when PARITY != 0, else STOP.
REQ-024 SHALL set perr when the received parity bit differs from the computed parity (odd: XOR of data and parity = 1; even: XOR = 0).
REQ-025 SHALL set ferr when any of the STOP_BITS stop samples is 0; ferr SHALL stop evaluation at the first 0 stop sample.
REQ-026 SHALL pulse o_break and enter WAIT_HIGH when ferr is set and all data bits (and parity, if used) are 0.
REQ-027 SHALL enter WAIT_HIGH on any ferr; WAIT_HIGH SHALL go to IDLE only when the synchronised line is 1.
REQ-028 SHALL push {data, perr, ferr} to the output buffer one clock after the majority decision of the final stop bit (or of the failing stop bit), including break frames.
REQ-029 SHALL transfer a word only on a cycle where o_valid && i_ready; o_data, o_perr and o_ferr SHALL stay stable while o_valid is high and i_ready is low.
REQ-030 SHALL drop the new frame and pulse o_overrun when a push occurs while the buffer is full and no pop occurs in that cycle; a simultaneous push and pop on a full buffer SHALL succeed.

Reset
REQ-031 SHALL, while i_rst is high, return to IDLE, clear counters and the buffer, and drive o_valid, o_overrun, o_break, o_perr and o_ferr to 0 and o_data to 0.
REQ-032 SHALL discard any partial frame when reset is asserted mid-frame; reception restarts only at a new falling edge after reset.

Configuration
REQ-033 SHALL, when UART_RX_FIFO_EN is defined, buffer frames in a FIFO_DEPTH-entry FIFO; o_valid = FIFO non-empty, with first-word-fall-through output.
REQ-034 SHALL, when UART_RX_FIFO_EN is undefined, use a single holding register (depth 1), with FIFO_DEPTH ignored.

Structure
REQ-035 SHALL place the parity-mode constants, the state enum typedef and the oversample constant 16 in the shared package uart_pkg.
REQ-036 SHALL implement the tick generator as sub-module uart_baud_tick, with a phase-restart input.

Verification (CLOCK_HZ=32000000, BAUD_RATE=1000000: DIV=2, 32 clk/bit)
REQ-037 SHALL cover: 8N1 frame 0xA5, i_ready=1 -> one o_valid with o_data=0xA5, perr=0, ferr=0, asserted 1 clock after the stop-bit decision.
REQ-038 SHALL cover: PARITY=2, 7 data bits, 0x41 sent with wrong parity -> o_data=0x41, perr=1; same frame with correct parity -> perr=0.
REQ-039 SHALL cover: 0.25-bit low glitch on an idle line -> no o_valid and state back in IDLE; a 1-clock glitch at mid-bit of data bit 3 -> majority keeps the bit value.
REQ-040 SHALL cover: line held low for 3 frame times -> one o_break pulse, one word with o_data=0x00 and ferr=1, no further frames until the line goes high.
REQ-041 SHALL cover: with FIFO, depth 4 and i_ready=0, 5 frames 0x01..0x05 -> 0x01..0x04 retained in order, one o_overrun pulse on the fifth; without FIFO, second frame -> o_overrun, o_data stays 0x01.
REQ-042 SHALL cover: i_rst pulsed during data bit 4 -> no o_valid; next frame 0x3C is received correctly.
